// File: rtl/karekok_alici_8bit_pkg.sv
// Shared definitions for the sequential integer square-root unit:
// controller states and default widths for the 8-bit radicand build.
package karekok_alici_8bit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } kk_state_e;

   localparam int KK_N      = 8;
   localparam int KK_ROOT_W = KK_N / 2;
   localparam int KK_REM_W  = KK_N / 2 + 1;
   localparam int KK_CNT_W  = $clog2(KK_N / 2);
   localparam int KK_WORK_W = KK_N / 2 + 3;

endpackage

// File: rtl/karekok_adim.sv
// One restoring square-root iteration: bring down two radicand bits, try to
// subtract (4*root + 1), and append the resulting root bit.
module karekok_adim
   import karekok_alici_8bit_pkg::*;
#(
   parameter int ROOT_W = KK_ROOT_W,
   parameter int REM_W  = ROOT_W + 1,
   parameter int WORK_W = ROOT_W + 3
) (
   input  logic [REM_W-1:0]  rem,
   input  logic [ROOT_W-1:0] root,
   input  logic [1:0]        bits,
   output logic [REM_W-1:0]  rem_next,
   output logic [ROOT_W-1:0] root_next
);

   logic [WORK_W-1:0] trial;
   logic [WORK_W-1:0] test;
   logic              ge;

   assign trial = {rem, bits};
   assign test  = {1'b0, root, 2'b01};
   assign ge    = (trial >= test);

   // The remainder never exceeds 2*root, so the upper working bits are zero
   // after either branch and truncation to REM_W is lossless.
   assign rem_next  = ge ? REM_W'(trial - test) : REM_W'(trial);
   assign root_next = {root[ROOT_W-2:0], ge};

endmodule

// File: rtl/karekok_alici_8bit.sv
// Sequential integer square root: f = floor(sqrt(a)), r = a - f*f, one root
// bit per clock over N/2 CALC cycles, with a start/busy/done handshake.
module karekok_alici_8bit
   import karekok_alici_8bit_pkg::*;
#(
   parameter int N = KK_N
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N-1:0]     a,
   output logic             busy,
   output logic             done,
   output logic [N/2-1:0]   f,
   output logic [N/2:0]     r
);

   localparam int ROOT_W = N / 2;
   localparam int REM_W  = N / 2 + 1;
   localparam int CNT_W  = $clog2(N / 2);

   kk_state_e         state;
   kk_state_e         state_next;
   logic              load;
   logic [N-1:0]      shift;
   logic [REM_W-1:0]  rem_q;
   logic [ROOT_W-1:0] root_q;
   logic [CNT_W-1:0]  cnt;
   logic [REM_W-1:0]  rem_next;
   logic [ROOT_W-1:0] root_next;

   karekok_adim #(
      .ROOT_W (ROOT_W)
   ) u_adim (
      .rem       (rem_q),
      .root      (root_q),
      .bits      (shift[N-1 -: 2]),
      .rem_next  (rem_next),
      .root_next (root_next)
   );

   // Handshake: start is sampled only while busy=0 (IDLE or DONE); the accepting
   // edge captures a. busy is high for the N/2 CALC cycles, done pulses for one
   // cycle with f/r already valid, and start while busy=1 is dropped.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == '0) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = CALC;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         shift  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt    <= '0;
         f      <= '0;
         r      <= '0;
      end else begin
         state <= state_next;
         if (load) begin
            shift  <= a;
            rem_q  <= '0;
            root_q <= '0;
            cnt    <= CNT_W'(N / 2 - 1);
         end else if (state == CALC) begin
            shift  <= shift << 2;
            rem_q  <= rem_next;
            root_q <= root_next;
            cnt    <= cnt - 1'b1;
            // Results are published only on the last iteration.
            if (cnt == '0) begin
               f <= root_next;
               r <= rem_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_karekok_alici_8bit.sv
// Self-checking bench for karekok_alici_8bit (N=8) against an arithmetic
// square-root reference model and an expected-result queue.
module tb_karekok_alici_8bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic       busy;
   logic       done;
   logic [3:0] f;
   logic [4:0] r;

   int n_checks = 0;
   int n_err    = 0;
   logic [8:0] exp_q[$];

   karekok_alici_8bit #(.N(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .busy  (busy),
      .done  (done),
      .f     (f),
      .r     (r)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // {root[3:0], remainder[4:0]} from plain integer arithmetic.
   function automatic logic [8:0] model(input int av);
      int s;
      s = 0;
      while ((s + 1) * (s + 1) <= av) s++;
      return 9'(s * 32 + (av - s * s));
   endfunction

   // Scoreboard: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            check("result_fr", {23'd0, f, r}, {23'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at the negedge right after the accepting edge.
   task automatic wait_done(output int lat, output int busy_cnt, output bit held);
      logic [3:0] f0;
      logic [4:0] r0;
      f0       = f;
      r0       = r;
      lat      = 0;
      busy_cnt = 0;
      held     = 1'b1;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         if (f !== f0 || r !== r0) held = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input logic [7:0] av);
      int lat, bc, fi, ri;
      bit held;
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      start = 1'b1;
      a     = av;
      exp_q.push_back(model(int'(av)));
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      wait_done(lat, bc, held);
      check("latency", lat, 4);
      check("busy_cycles", bc, 4);
      check("hold_during_calc", {31'd0, held}, 32'd1);
      check("busy_at_done", {31'd0, busy}, 32'd0);
      fi = int'(f);
      ri = int'(r);
      check("f2_plus_r", fi * fi + ri, int'(av));
      check("r_le_2f", {31'd0, ri <= 2 * fi}, 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat, bc, fi, ri;
      bit held, ok;
      logic [3:0] fh;
      logic [4:0] rh;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      do_reset();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_f", {28'd0, f}, 32'd0);
      check("rst_r", {27'd0, r}, 32'd0);
      ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (f !== 4'd0 || r !== 5'd0 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
      end
      check("rst_hold_10", {31'd0, ok}, 32'd1);

      // Directed values
      run_op(8'd144);
      check("f_144", {28'd0, f}, 32'd12);
      check("r_144", {27'd0, r}, 32'd0);
      run_op(8'd143);
      check("f_143", {28'd0, f}, 32'd11);
      check("r_143", {27'd0, r}, 32'd22);
      run_op(8'd0);
      check("f_0", {28'd0, f}, 32'd0);
      check("r_0", {27'd0, r}, 32'd0);
      run_op(8'd255);
      check("f_255", {28'd0, f}, 32'd15);
      check("r_255", {27'd0, r}, 32'd30);

      // Exhaustive sweep
      for (int i = 0; i < 256; i++) run_op(8'(i));

      // Results hold while idle
      fh = f;
      rh = r;
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (f !== fh || r !== rh || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
      end
      check("idle_hold_20", {31'd0, ok}, 32'd1);

      // Start while busy is ignored
      @(negedge clk);
      start = 1'b1;
      a     = 8'd200;
      exp_q.push_back(model(200));
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      @(negedge clk);
      start = 1'b1;
      a     = 8'd9;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc, held);
      check("f_200", {28'd0, f}, 32'd14);
      check("r_200", {27'd0, r}, 32'd4);
      repeat (8) @(negedge clk);
      check("busy_ignore_idle", {31'd0, busy}, 32'd0);

      // Back-to-back with start held high
      start = 1'b1;
      a     = 8'd81;
      exp_q.push_back(model(81));
      @(negedge clk);
      a = 8'($urandom);
      wait_done(lat, bc, held);
      check("b2b_lat1", lat, 4);
      check("f_81", {28'd0, f}, 32'd9);
      check("r_81", {27'd0, r}, 32'd0);
      a = 8'd50;
      exp_q.push_back(model(50));
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      check("b2b_no_gap", {31'd0, busy}, 32'd1);
      wait_done(lat, bc, held);
      check("b2b_lat2", lat, 4);
      check("f_50", {28'd0, f}, 32'd7);
      check("r_50", {27'd0, r}, 32'd1);

      // Reset during CALC
      @(negedge clk);
      start = 1'b1;
      a     = 8'd100;
      exp_q.push_back(model(100));
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_f", {28'd0, f}, 32'd0);
      check("abort_r", {27'd0, r}, 32'd0);
      rst = 1'b0;
      ok  = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (f !== 4'd0 || r !== 5'd0 || busy !== 1'b0) ok = 1'b0;
      end
      check("abort_stays_idle", {31'd0, ok}, 32'd1);

      // Random operations
      repeat (20) run_op(8'($urandom_range(0, 255)));

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
